// File: rtl/regfile_wb_queue_if.sv
// Write-back queue bus: two producer ports, register-file write port, busy query.
interface regfile_wb_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     ld_valid;
  logic                     ld_ready;
  logic [4:0]               ld_addr;
  logic [31:0]              ld_data;
  logic                     alu_valid;
  logic                     alu_ready;
  logic [4:0]               alu_addr;
  logic [31:0]              alu_data;
  logic                     wb_hold;
  logic                     RegWrite;
  logic [4:0]               WriteAddr;
  logic [31:0]              WriteData;
  logic [4:0]               chk_addr1;
  logic [4:0]               chk_addr2;
  logic                     busy1;
  logic                     busy2;
  logic [$clog2(DEPTH):0]   q_count;

  modport master (
    output ld_valid, ld_addr, ld_data, alu_valid, alu_addr, alu_data, wb_hold,
    output chk_addr1, chk_addr2,
    input  ld_ready, alu_ready, RegWrite, WriteAddr, WriteData, busy1, busy2, q_count
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, alu_valid, alu_addr, alu_data, wb_hold,
    input  chk_addr1, chk_addr2,
    output ld_ready, alu_ready, RegWrite, WriteAddr, WriteData, busy1, busy2, q_count
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order register write-back queue fed by the load unit and the ALU.
// Head entry is presented combinationally and retired on every edge it is driven.
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  regfile_wb_queue_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [4:0]      entryAddr [DEPTH];
  logic [31:0]     entryData [DEPTH];
  logic [PtrW-1:0] headPtr;
  logic [PtrW-1:0] tailPtr;
  logic [CntW-1:0] count;

  logic            notFull;
  logic            ldFire;
  logic            aluFire;
  logic            doEnq;
  logic            doDeq;
  logic [4:0]      enqAddr;
  logic [31:0]     enqData;
  logic [DEPTH-1:0] entryValid;

  // Handshakes and enqueue selection; load has fixed priority over ALU.
  always_comb begin
    notFull       = count < Full;
    bus.ld_ready  = notFull;
    bus.alu_ready = notFull && !bus.ld_valid;
    ldFire        = bus.ld_valid && notFull;
    aluFire       = bus.alu_valid && notFull && !bus.ld_valid;
    enqAddr       = ldFire ? bus.ld_addr : bus.alu_addr;
    enqData       = ldFire ? bus.ld_data : bus.alu_data;
    // Writes to r0 complete the handshake but are dropped.
    doEnq         = (ldFire || aluFire) && (enqAddr != 5'd0);
    bus.q_count   = count;
  end

  // Head drive: present the oldest entry unless draining is held off.
  always_comb begin
    doDeq         = (count != '0) && !bus.wb_hold;
    bus.RegWrite  = doDeq;
    bus.WriteAddr = doDeq ? entryAddr[headPtr] : 5'd0;
    bus.WriteData = doDeq ? entryData[headPtr] : 32'd0;
  end

  // Pending-write lookup over all valid entries, head included.
  always_comb begin
    bus.busy1 = 1'b0;
    bus.busy2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // Entry i is valid when its distance from head is below count.
      entryValid[i] = {1'b0, PtrW'(i) - headPtr} < count;
      if (entryValid[i] && (bus.chk_addr1 != 5'd0) && (entryAddr[i] == bus.chk_addr1)) begin
        bus.busy1 = 1'b1;
      end
      if (entryValid[i] && (bus.chk_addr2 != 5'd0) && (entryAddr[i] == bus.chk_addr2)) begin
        bus.busy2 = 1'b1;
      end
    end
  end

  // Pointer and occupancy state; reset discards every queued entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doEnq) tailPtr <= tailPtr + 1'b1;
      if (doDeq) headPtr <= headPtr + 1'b1;
      case ({doEnq, doDeq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningful only where entryValid is set.
  always_ff @(posedge clock) begin
    if (doEnq && !reset) begin
      entryAddr[tailPtr] <= enqAddr;
      entryData[tailPtr] <= enqData;
    end
  end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench: stimulus pushes expected writes into a scoreboard, a negedge
// monitor pops and compares every register-file write.
module tb_regfile_wb_queue;
  logic clock;
  logic reset;
  int   tests;
  int   fails;
  logic [36:0] sb [$];

  regfile_wb_queue_if #(.DEPTH(4)) bus ();

  regfile_wb_queue #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every observed write must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && bus.RegWrite === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write_addr", {27'd0, bus.WriteAddr}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        check("wb_addr", {27'd0, bus.WriteAddr}, {27'd0, e[36:32]});
        check("wb_data", bus.WriteData, e[31:0]);
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0;
    bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
    bus.wb_hold = 0; bus.chk_addr1 = 0; bus.chk_addr2 = 0;

    // Reset state
    #2;
    check("rst_q_count", {29'd0, bus.q_count}, 32'd0);
    check("rst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
    check("rst_WriteAddr", {27'd0, bus.WriteAddr}, 32'd0);
    check("rst_WriteData", bus.WriteData, 32'd0);
    check("rst_busy1", {31'd0, bus.busy1}, 32'd0);
    check("rst_busy2", {31'd0, bus.busy2}, 32'd0);
    check("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    check("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single load write, one-cycle latency, busy tracking
    bus.ld_valid = 1; bus.ld_addr = 5; bus.ld_data = 32'hDEAD_BEEF; bus.chk_addr1 = 5;
    sb.push_back({5'd5, 32'hDEAD_BEEF});
    tick();
    bus.ld_valid = 0;
    @(negedge clock);
    check("t1_RegWrite", {31'd0, bus.RegWrite}, 32'd1);
    check("t1_busy1", {31'd0, bus.busy1}, 32'd1);
    check("t1_q_count", {29'd0, bus.q_count}, 32'd1);
    tick();
    @(negedge clock);
    check("t1_RegWrite_off", {31'd0, bus.RegWrite}, 32'd0);
    check("t1_busy1_off", {31'd0, bus.busy1}, 32'd0);
    check("t1_q_count_0", {29'd0, bus.q_count}, 32'd0);
    tick();

    // Load priority over ALU
    bus.ld_valid = 1; bus.ld_addr = 3; bus.ld_data = 32'h33;
    bus.alu_valid = 1; bus.alu_addr = 4; bus.alu_data = 32'h44;
    #1;
    check("t2_alu_ready_blocked", {31'd0, bus.alu_ready}, 32'd0);
    check("t2_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    sb.push_back({5'd3, 32'h33});
    tick();
    bus.ld_valid = 0;
    #1;
    check("t2_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    sb.push_back({5'd4, 32'h44});
    tick();
    bus.alu_valid = 0;
    tick();
    tick();

    // Hold: fill to capacity, then drain in order
    bus.wb_hold = 1;
    bus.alu_valid = 1;
    for (int i = 1; i <= 5; i++) begin
      bus.alu_addr = 5'(i);
      bus.alu_data = 32'h100 + 32'(i);
      #1;
      check("t3_alu_ready", {31'd0, bus.alu_ready}, (i <= 4) ? 32'd1 : 32'd0);
      if (i <= 4) begin
        sb.push_back({5'(i), 32'h100 + 32'(i)});
        tick();
      end
    end
    @(negedge clock);
    check("t3_q_count_full", {29'd0, bus.q_count}, 32'd4);
    check("t3_ld_ready_full", {31'd0, bus.ld_ready}, 32'd0);
    tick();
    bus.wb_hold = 0;
    #1;
    check("t3_no_passthrough", {31'd0, bus.alu_ready}, 32'd0);
    tick();
    check("t3_alu_ready_after", {31'd0, bus.alu_ready}, 32'd1);
    sb.push_back({5'd5, 32'h105});
    tick();
    bus.alu_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    check("t3_drained", {29'd0, bus.q_count}, 32'd0);

    // Write to r0 is accepted but dropped
    bus.alu_valid = 1; bus.alu_addr = 0; bus.alu_data = 32'hFFFF_FFFF; bus.chk_addr1 = 0;
    #1;
    check("t4_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    tick();
    bus.alu_valid = 0;
    @(negedge clock);
    check("t4_q_count", {29'd0, bus.q_count}, 32'd0);
    check("t4_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
    check("t4_busy1", {31'd0, bus.busy1}, 32'd0);
    tick();

    // Same register twice, in order, busy until second retires
    bus.chk_addr1 = 7; bus.chk_addr2 = 7;
    bus.ld_valid = 1; bus.ld_addr = 7; bus.ld_data = 32'h1;
    sb.push_back({5'd7, 32'h1});
    tick();
    bus.ld_data = 32'h2;
    sb.push_back({5'd7, 32'h2});
    @(negedge clock);
    check("t5_busy1_first", {31'd0, bus.busy1}, 32'd1);
    tick();
    bus.ld_valid = 0;
    @(negedge clock);
    check("t5_busy2_second", {31'd0, bus.busy2}, 32'd1);
    check("t5_q_count", {29'd0, bus.q_count}, 32'd1);
    tick();
    @(negedge clock);
    check("t5_busy1_clear", {31'd0, bus.busy1}, 32'd0);
    tick();

    // Asynchronous reset mid-operation discards held entries
    bus.wb_hold = 1; bus.chk_addr1 = 9; bus.chk_addr2 = 11;
    bus.ld_valid = 1;
    for (int i = 9; i <= 11; i++) begin
      bus.ld_addr = 5'(i);
      bus.ld_data = 32'(i);
      tick();
    end
    bus.ld_valid = 0;
    @(negedge clock);
    check("t6_q_count_3", {29'd0, bus.q_count}, 32'd3);
    check("t6_busy1_pre", {31'd0, bus.busy1}, 32'd1);
    check("t6_busy2_pre", {31'd0, bus.busy2}, 32'd1);
    #1;
    bus.wb_hold = 0;
    reset = 1'b1;
    bus.ld_valid = 1; bus.ld_addr = 12; bus.ld_data = 32'hC;
    #1;
    check("t6_q_count_rst", {29'd0, bus.q_count}, 32'd0);
    check("t6_RegWrite_rst", {31'd0, bus.RegWrite}, 32'd0);
    check("t6_busy1_rst", {31'd0, bus.busy1}, 32'd0);
    check("t6_busy2_rst", {31'd0, bus.busy2}, 32'd0);
    tick();
    check("t6_no_enq_in_rst", {29'd0, bus.q_count}, 32'd0);
    reset = 1'b0;
    sb.push_back({5'd12, 32'hC});
    tick();
    bus.ld_valid = 0;
    @(negedge clock);
    check("t6_q_count_after", {29'd0, bus.q_count}, 32'd1);
    tick();
    tick();
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, write-queue entries; power of two, >= 2.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ld_valid  input  1  load unit offers a register write.
REQ-005 ld_ready  output  1  queue accepts the load write this cycle.
REQ-006 ld_addr  input  5  load destination register.
REQ-007 ld_data  input  32  load result.
REQ-008 alu_valid  input  1  ALU offers a register write.
REQ-009 alu_ready  output  1  queue accepts the ALU write this cycle.
REQ-010 alu_addr  input  5  ALU destination register.
REQ-011 alu_data  input  32  ALU result.
REQ-012 wb_hold  input  1  suspend draining; queue contents held.
REQ-013 RegWrite  output  1  register-file write enable.
REQ-014 WriteAddr  output  5  register-file write address.
REQ-015 WriteData  output  32  register-file write data.
REQ-016 chk_addr1, chk_addr2  input  5 each  source registers queried by issue logic.
REQ-017 busy1, busy2  output  1 each  queried register has a pending queued write.
REQ-018 q_count  output  clog2(DEPTH)+1 (3 at default)  valid entries in queue.

Function
REQ-019 Circular FIFO of {addr[4:0], data[31:0]} entries; head and tail pointers wrap modulo DEPTH; count tracked separately.
REQ-020 Transfer on a port occurs at a rising edge where valid && ready are both 1.
REQ-021 At most one enqueue per cycle; ld has fixed priority over alu.
REQ-022 ld_ready = (q_count < DEPTH); independent of ld_valid.
REQ-023 alu_ready = (q_count < DEPTH) && !ld_valid.
REQ-024 Full queue: both ready low, even if a dequeue occurs the same cycle (no pass-through).
REQ-025 Transfer with addr == 0: handshake completes, nothing enqueued, q_count unchanged.
REQ-026 Head drive, combinational: queue non-empty && !wb_hold -> RegWrite=1, WriteAddr/WriteData = head entry; otherwise RegWrite=0, WriteAddr=0, WriteData=0.
REQ-027 Dequeue at every rising edge where RegWrite=1; head advances by one.
REQ-028 Latency: entry enqueued at edge N into an empty, unheld queue drives RegWrite during cycle N..N+1 and is written by the register file at edge N+1.
REQ-029 Writes leave in enqueue order; two entries for the same register are never reordered or merged.
REQ-030 Simultaneous enqueue and dequeue: q_count unchanged; both pointers advance.
REQ-031 busyK = 1 iff chk_addrK != 0 and any valid entry, head included, has addr == chk_addrK; combinational.
REQ-032 busy drops in the cycle after the last matching entry is dequeued.
REQ-033 wb_hold: no dequeue; enqueue continues until full.

Reset
REQ-034 Reset asserted: pointers=0, q_count=0, RegWrite=0, WriteAddr=0, WriteData=0, busy1=busy2=0, ld_ready=alu_ready=1 (when ld_valid=0); queued entries discarded.
REQ-035 Reset asserted mid-operation: takes effect immediately, without waiting for a clock edge; no handshake completes at an edge while reset is high.
REQ-036 Entry storage data need not be cleared; only valid state matters.

Verification
REQ-037 Empty queue, ld_valid=1, ld_addr=5, ld_data=0xDEADBEEF for one edge -> next cycle RegWrite=1, WriteAddr=5, WriteData=0xDEADBEEF, busy for chk_addr1=5 high; following cycle RegWrite=0, busy1=0, q_count=0.
REQ-038 ld_valid=alu_valid=1 (ld addr 3, alu addr 4) -> alu_ready=0; reg 3 queued first; alu write to reg 4 accepted on the next edge after ld_valid drops.
REQ-039 wb_hold=1, five alu writes to regs 1..5 offered back-to-back -> four accepted, q_count=4, alu_ready=0; release hold -> RegWrite for 1,2,3,4 on consecutive cycles, then reg 5 accepted.
REQ-040 alu write addr=0, data=0xFFFFFFFF -> alu_ready=1, q_count stays 0, RegWrite never asserts; chk_addr1=0 -> busy1=0.
REQ-041 Two writes to reg 7 (0x1 then 0x2) -> WriteData 0x1 then 0x2 in order; busy for reg 7 stays high until the second dequeues.
REQ-042 Queue holding 3 entries with wb_hold=1, reset pulsed between edges -> q_count=0, RegWrite=0, busy1=busy2=0 immediately; normal operation on the next edge after reset drops.
